// File: rtl/func_call_responder_pkg.sv
// Shared types and constants for the function-call responder.
package func_call_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned RET_OFFSET = 2;
  localparam int unsigned B_OFFSET   = 1;

endpackage

// File: rtl/func_call_responder_if.sv
// Call request / response bundle between the call sequencer (master) and the responder (slave).
interface func_call_responder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             i_req_valid;
  logic             o_req_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_divisor;
  logic [WIDTH-1:0] i_c;
  logic             o_rsp_valid;
  logic             i_rsp_ready;
  logic [WIDTH-1:0] o_ret;
  logic [WIDTH-1:0] o_b;
  logic [WIDTH-1:0] o_c;
  logic             o_div_by_zero;

  modport slave (
    input  i_req_valid, i_a, i_divisor, i_c, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_ret, o_b, o_c, o_div_by_zero
  );

  modport master (
    output i_req_valid, i_a, i_divisor, i_c, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_ret, o_b, o_c, o_div_by_zero
  );
endinterface

// File: rtl/func_call_responder_divider.sv
// Restoring unsigned divider, one quotient bit per cycle MSB first, WIDTH cycles per divide.
// quotient is the value being written on the cycle done is high (valid alongside done).
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [WIDTH:0]   trial, diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic             unused_msb;

  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]};
    diff  = trial - {1'b0, dvs_q};
    qbit  = (trial >= {1'b0, dvs_q});
    // Restored/subtracted remainder always fits WIDTH bits since it stays below the divisor.
    {unused_msb, rem_d} = qbit ? diff : trial;
    quo_d = {quo_q[WIDTH-2:0], qbit};
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign quotient = quo_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/func_call_responder.sv
// Callee side of the function-call model: ret = a+2, b = a+1+d, ref c = a / divisor.
// Optional FUNC_CALL_RESPONDER_UNIT_DIV_FASTPATH_EN answers divisor==1 calls without dividing.
module func_call_responder
  import func_call_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned D_CONST = 1
) (
  input logic                  i_clk,
  input logic                  i_rst,
  func_call_responder_if.slave bus
);
  state_t           state_q;
  logic             rsp_valid_q, dz_q;
  logic [WIDTH-1:0] ret_q, b_q, c_q;
  logic             accept, div_zero, unit_div, div_start;
  logic             div_busy, div_done;
  logic [WIDTH-1:0] div_quotient;

  assign bus.o_req_ready   = (state_q == IDLE) && !i_rst;
  assign bus.o_rsp_valid   = rsp_valid_q;
  assign bus.o_ret         = ret_q;
  assign bus.o_b           = b_q;
  assign bus.o_c           = c_q;
  assign bus.o_div_by_zero = dz_q;

  assign accept   = bus.i_req_valid && bus.o_req_ready;
  assign div_zero = (bus.i_divisor == '0);
`ifdef FUNC_CALL_RESPONDER_UNIT_DIV_FASTPATH_EN
  assign unit_div = (bus.i_divisor == WIDTH'(1));
`else
  assign unit_div = 1'b0;
`endif
  assign div_start = accept && !div_zero && !unit_div;

  seq_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .start    (div_start),
    .dividend (bus.i_a),
    .divisor  (bus.i_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      ret_q       <= '0;
      b_q         <= '0;
      c_q         <= '0;
      dz_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            ret_q <= bus.i_a + WIDTH'(RET_OFFSET);
            b_q   <= bus.i_a + WIDTH'(B_OFFSET) + WIDTH'(D_CONST);
            if (div_zero) begin
              c_q         <= bus.i_c;
              dz_q        <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else if (unit_div) begin
              c_q         <= bus.i_a;
              dz_q        <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              state_q <= DIV;
            end
          end
        end
        DIV: begin
          if (div_done) begin
            c_q         <= div_quotient;
            dz_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (!div_busy) begin
            state_q <= IDLE;  // divider lost its operation; recover rather than hang
          end
        end
        RESP: begin
          if (bus.i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_func_call_responder.sv
// Self-checking bench for func_call_responder: vector table + expected-result queue.
module tb_func_call_responder;
  localparam int unsigned WIDTH = 8;
`ifdef FUNC_CALL_RESPONDER_UNIT_DIV_FASTPATH_EN
  localparam int LAT_UNIT = 1;
`else
  localparam int LAT_UNIT = 9;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] dv;
    logic [7:0] c;
    logic [7:0] ret;
    logic [7:0] b;
    logic [7:0] qc;
    logic       dz;
    int         lat;
    logic       early;
    int         hold;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  func_call_responder_if #(.WIDTH(WIDTH)) bus ();

  func_call_responder #(
    .WIDTH   (WIDTH),
    .D_CONST (1)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t exp_q[$];
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_call(input vec_t v);
    vec_t e;
    int   lat;
    int   w;
    w = 0;
    while (!bus.o_req_ready && w < 50) begin
      step();
      w++;
    end
    chk("req_ready_before_call", {31'd0, bus.o_req_ready}, 32'd1);
    bus.i_req_valid = 1'b1;
    bus.i_a         = v.a;
    bus.i_divisor   = v.dv;
    bus.i_c         = v.c;
    bus.i_rsp_ready = v.early;
    exp_q.push_back(v);
    step();
    bus.i_req_valid = 1'b0;
    lat = 1;
    // Inputs are scrambled while the call is in flight; they must be ignored.
    while (!bus.o_rsp_valid && lat < 40) begin
      bus.i_a       = 8'($urandom);
      bus.i_divisor = 8'($urandom);
      bus.i_c       = 8'($urandom);
      step();
      lat++;
    end
    e = exp_q.pop_front();
    chk("latency", lat, e.lat);
    if (e.hold > 0) bus.i_rsp_ready = 1'b0;
    for (int k = 0; k <= e.hold; k++) begin
      chk("rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd1);
      chk("req_ready_in_resp", {31'd0, bus.o_req_ready}, 32'd0);
      chk("ret", {24'd0, bus.o_ret}, {24'd0, e.ret});
      chk("b", {24'd0, bus.o_b}, {24'd0, e.b});
      chk("c", {24'd0, bus.o_c}, {24'd0, e.qc});
      chk("div_by_zero", {31'd0, bus.o_div_by_zero}, {31'd0, e.dz});
      if (k < e.hold) step();
    end
    bus.i_rsp_ready = 1'b1;
    step();
    bus.i_rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", {31'd0, bus.o_rsp_valid}, 32'd0);
    chk("req_ready_after_hs", {31'd0, bus.o_req_ready}, 32'd1);
    chk("c_held_in_idle", {24'd0, bus.o_c}, {24'd0, e.qc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic saw;

    tbl[0] = '{a:8'd10,  dv:8'd3,   c:8'h55, ret:8'd12,  b:8'd12,  qc:8'd3,
               dz:1'b0, lat:9, early:1'b1, hold:0};
    tbl[1] = '{a:8'hFF,  dv:8'd1,   c:8'h00, ret:8'h01,  b:8'h01,  qc:8'hFF,
               dz:1'b0, lat:LAT_UNIT, early:1'b0, hold:0};
    tbl[2] = '{a:8'd7,   dv:8'd0,   c:8'h5A, ret:8'd9,   b:8'd9,   qc:8'h5A,
               dz:1'b1, lat:1, early:1'b0, hold:0};
    tbl[3] = '{a:8'd100, dv:8'd10,  c:8'h11, ret:8'd102, b:8'd102, qc:8'd10,
               dz:1'b0, lat:9, early:1'b0, hold:5};
    tbl[4] = '{a:8'd255, dv:8'd255, c:8'h22, ret:8'd1,   b:8'd1,   qc:8'd1,
               dz:1'b0, lat:9, early:1'b1, hold:0};
    tbl[5] = '{a:8'd0,   dv:8'd5,   c:8'h33, ret:8'd2,   b:8'd2,   qc:8'd0,
               dz:1'b0, lat:9, early:1'b0, hold:0};
    tbl[6] = '{a:8'd254, dv:8'd0,   c:8'h00, ret:8'd0,   b:8'd0,   qc:8'h00,
               dz:1'b1, lat:1, early:1'b0, hold:2};
    tbl[7] = '{a:8'd13,  dv:8'd200, c:8'h77, ret:8'd15,  b:8'd15,  qc:8'd0,
               dz:1'b0, lat:9, early:1'b0, hold:0};
    tbl[8] = '{a:8'd129, dv:8'd2,   c:8'h66, ret:8'd131, b:8'd131, qc:8'd64,
               dz:1'b0, lat:9, early:1'b1, hold:1};

    bus.i_req_valid = 1'b0;
    bus.i_a         = '0;
    bus.i_divisor   = '0;
    bus.i_c         = '0;
    bus.i_rsp_ready = 1'b0;

    // Reset state, with a request pending that must not be taken.
    bus.i_req_valid = 1'b1;
    step();
    step();
    chk("rst_req_ready", {31'd0, bus.o_req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
    chk("rst_outputs", {bus.o_ret, bus.o_b, bus.o_c}, 32'd0);
    chk("rst_dz", {31'd0, bus.o_div_by_zero}, 32'd0);
    bus.i_req_valid = 1'b0;
    rst = 1'b0;
    step();
    chk("idle_req_ready", {31'd0, bus.o_req_ready}, 32'd1);

    for (int i = 0; i < 9; i++) do_call(tbl[i]);

    // Reset in the middle of a divide: outputs clear at once, no response follows.
    bus.i_req_valid = 1'b1;
    bus.i_a         = 8'd200;
    bus.i_divisor   = 8'd7;
    bus.i_c         = 8'h44;
    step();
    bus.i_req_valid = 1'b0;
    repeat (3) step();
    chk("pre_rst_in_div", {31'd0, bus.o_req_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
    chk("midrst_req_ready", {31'd0, bus.o_req_ready}, 32'd0);
    chk("midrst_outputs", {bus.o_ret, bus.o_b, bus.o_c}, 32'd0);
    chk("midrst_dz", {31'd0, bus.o_div_by_zero}, 32'd0);
    step();
    rst = 1'b0;
    saw = 1'b0;
    repeat (15) begin
      step();
      if (bus.o_rsp_valid) saw = 1'b1;
    end
    chk("no_rsp_after_rst", {31'd0, saw}, 32'd0);

    v = '{a:8'd200, dv:8'd7, c:8'h44, ret:8'd202, b:8'd202, qc:8'd28,
          dz:1'b0, lat:9, early:1'b0, hold:0};
    do_call(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/func_call_responder.md
Name: func_call_responder

Overview:
- Callee-side hardware implementation of the team's function-call model.
- Accepts a call request carrying the `a` argument, the incoming value of the `ref` argument `c`, and a divisor.
- Returns the return value, output argument `b` and updated `ref` argument `c` over a valid/ready response channel.
- Sits behind the call sequencer. The division path is multi-cycle; every other result is computed at accept.

Parameters:
- WIDTH, 8, bit width of all argument/result datapaths (>=2).
- D_CONST, 1, local constant `d` added into `b`; truncated to WIDTH bits.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous reset, active-high.
- i_req_valid  input  1  call request valid.
- o_req_ready  output  1  responder can accept a call.
- i_a  input  WIDTH  argument `a`.
- i_divisor  input  WIDTH  divisor for the `c` update.
- i_c  input  WIDTH  incoming value of ref argument `c`.
- o_rsp_valid  output  1  response valid.
- i_rsp_ready  input  1  consumer accepts response.
- o_ret  output  WIDTH  return value.
- o_b  output  WIDTH  output argument `b`.
- o_c  output  WIDTH  final value of ref argument `c`.
- o_div_by_zero  output  1  divisor was zero; `c` left unmodified.

Behaviour:
- Reset (async, i_rst=1): state IDLE; o_req_ready=0 while reset asserted; o_rsp_valid=0; o_ret, o_b, o_c = 0; o_div_by_zero=0; divider registers cleared.
- Reset mid-call aborts immediately; no response is produced for an in-flight call.
- Request handshake: accept when i_req_valid && o_req_ready on a rising edge.
- o_req_ready=1 only in IDLE.
- At accept, register:
  - o_ret = (a + 2) mod 2^WIDTH
  - o_b = (a + 1 + D_CONST) mod 2^WIDTH
  - i_c and i_divisor latched.
- FSM states: IDLE, DIV, RESP.
  - IDLE -> DIV on accept with divisor != 0.
  - IDLE -> RESP on accept with divisor == 0. o_c = latched i_c (ref not written); o_div_by_zero=1.
  - DIV: restoring unsigned division, one quotient bit per cycle, MSB first, exactly WIDTH cycles. Then -> RESP with o_c = quotient (remainder discarded) and o_div_by_zero=0.
  - RESP: o_rsp_valid=1; outputs held stable until i_rsp_ready=1. On the handshake edge -> IDLE and o_rsp_valid=0.
- Latency, accept edge to o_rsp_valid high:
  - WIDTH+1 cycles for divisor != 0.
  - 1 cycle for divisor == 0.
- No back-to-back overlap. A new request is accepted no earlier than the cycle after the response handshake, because o_req_ready is low in RESP.
- Inputs are sampled only at accept; changes on i_a/i_divisor/i_c during DIV/RESP are ignored.
- i_rsp_ready asserted before o_rsp_valid has no effect.
- Outputs keep their last values in IDLE.

Optional Feature:
- Macro FUNC_CALL_RESPONDER_UNIT_DIV_FASTPATH_EN.
- Defined: on accept with divisor == 1, skip DIV. Go IDLE -> RESP with o_c = a (the a/1 identity); latency 1 cycle.
- Undefined: divisor == 1 goes through the full WIDTH-cycle DIV path. Results are identical; only latency differs.

Decomposition:
- Package func_call_pkg holds:
  - state enum (IDLE, DIV, RESP) as a 2-bit logic typedef;
  - RET_OFFSET = 2;
  - B_OFFSET = 1.
- One sub-module, seq_divider (parameter WIDTH):
  - Inputs: start, dividend, divisor.
  - Outputs: busy, done pulse, quotient.
  - Async active-high reset, shared i_clk/i_rst.
- Top holds the FSM, the handshakes and the adders.

Test Plan:
- WIDTH=8, D_CONST=1, a=10, divisor=3, i_c=0x55, i_rsp_ready=1 -> o_rsp_valid high 9 cycles after accept; o_ret=12, o_b=12, o_c=3, o_div_by_zero=0.
- a=0xFF, divisor=1 -> o_ret=0x01 (wrap), o_b=0x01 (wrap), o_c=0xFF. Latency 9 cycles without the macro, 1 cycle with it.
- a=7, divisor=0, i_c=0x5A -> response 1 cycle after accept; o_c=0x5A, o_div_by_zero=1, o_ret=9, o_b=9.
- Backpressure: i_rsp_ready=0 for 5 cycles in RESP -> o_rsp_valid stays 1, outputs stable, o_req_ready=0. When ready rises -> one handshake, then IDLE with o_req_ready=1 the next cycle.
- Assert i_rst for 1 cycle at DIV cycle 4 of a/divisor=200/7 -> all outputs zero immediately, no response emitted. The next request (a=200, divisor=7) returns o_c=28.
- Change i_a/i_divisor every cycle during DIV -> results match values sampled at accept.
